// File: rtl/branch_tag_allocator_pkg.sv
// Shared types and helpers for the branch tag allocator: tag/mask types, resolve record,
// circular age and one-hot helpers.
package branch_tag_allocator_pkg;

  localparam int MAX_BRANCH_IF = 4;
  localparam int TAG_BITS      = $clog2(MAX_BRANCH_IF);
  localparam int CNT_BITS      = 20;

  typedef logic [TAG_BITS-1:0]      btag_t;
  typedef logic [MAX_BRANCH_IF-1:0] btag_mask_t;

  typedef struct packed {
    logic  valid;
    btag_t tag;
    logic  mispred;
  } btag_resolve_t;

  // Distance back from the most recently allocated tag (head-1); 0 is the youngest.
  function automatic btag_t btag_age(btag_t head, btag_t tag);
    return head - tag - btag_t'(1);
  endfunction

  function automatic btag_mask_t btag_onehot(btag_t tag);
    return btag_mask_t'(1) << tag;
  endfunction

endpackage

// File: rtl/branch_tag_allocator_age_cmp.sv
// btag_age_cmp: relative age of one tag and the mask of busy tags younger than it.
module btag_age_cmp
  import branch_tag_allocator_pkg::*;
(
  input  btag_t      i_head,
  input  btag_mask_t i_busy,
  input  btag_t      i_tag,
  output btag_t      o_age,
  output btag_mask_t o_kill_mask
);

  assign o_age = btag_age(i_head, i_tag);

  always_comb begin
    o_kill_mask = '0;
    for (int t = 0; t < MAX_BRANCH_IF; t++) begin
      o_kill_mask[t] = i_busy[t] && (btag_age(i_head, btag_t'(t)) < o_age);
    end
  end

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch tag allocator for a dual-issue decoder: circular allocation, EX resolution, mispredict
// kill masks. Optional perf counters are enabled with the BTAG_PERF_CNT_EN macro.
module branch_tag_allocator
  import branch_tag_allocator_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       alloc_req_1,
  input  logic       alloc_req_2,
  input  logic       alloc_fire_i,
  output logic       alloc_stall_o,
  output btag_t      tag_1_o,
  output btag_t      tag_2_o,
  input  logic       res_valid_1,
  input  btag_t      res_tag_1,
  input  logic       res_mispred_1,
  input  logic       res_valid_2,
  input  btag_t      res_tag_2,
  input  logic       res_mispred_2,
  input  logic       flush_all_i,
  output logic       flush_o,
  output btag_t      flush_tag_o,
  output btag_mask_t kill_mask_o,
  output btag_mask_t busy_mask_o
`ifdef BTAG_PERF_CNT_EN
  ,
  output logic [4*CNT_BITS-1:0] perf_cnt_o
`endif
);

  btag_mask_t    r_busy;
  btag_mask_t    r_kill;
  btag_t         r_head;
  btag_t         r_flush_tag;
  logic          r_flush;

  logic [1:0]    w_need;
  btag_t         w_head_p1;
  logic          w_commit;
  btag_mask_t    w_alloc_mask;
  btag_mask_t    w_clr_mask;
  btag_resolve_t w_res_1;
  btag_resolve_t w_res_2;
  logic          w_hit_1;
  logic          w_hit_2;
  logic          w_mp_1;
  logic          w_mp_2;
  logic          w_mp_any;
  logic          w_pick_2;
  btag_t         w_age_1;
  btag_t         w_age_2;
  btag_mask_t    w_kill_1;
  btag_mask_t    w_kill_2;
  btag_t         w_mp_tag;
  btag_mask_t    w_mp_kill;
  btag_mask_t    w_busy_nxt;
  btag_t         w_head_nxt;

  assign w_need        = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
  assign w_head_p1     = r_head + btag_t'(1);
  assign alloc_stall_o = ((w_need != 2'd0) && r_busy[r_head]) ||
                         ((w_need == 2'd2) && r_busy[w_head_p1]) || r_flush;
  assign tag_1_o       = r_head;
  assign tag_2_o       = (alloc_req_1 && alloc_req_2) ? w_head_p1 : r_head;
  assign w_commit      = alloc_fire_i && !alloc_stall_o && (w_need != 2'd0);

  assign w_res_1 = {res_valid_1, res_tag_1, res_mispred_1};
  assign w_res_2 = {res_valid_2, res_tag_2, res_mispred_2};
  // Resolutions of tags that are not in flight (including ones just killed) are dropped here.
  assign w_hit_1 = w_res_1.valid && r_busy[w_res_1.tag];
  assign w_hit_2 = w_res_2.valid && r_busy[w_res_2.tag];
  assign w_mp_1  = w_hit_1 && w_res_1.mispred;
  assign w_mp_2  = w_hit_2 && w_res_2.mispred;

  btag_age_cmp u_age_1 (
    .i_head      (r_head),
    .i_busy      (r_busy),
    .i_tag       (w_res_1.tag),
    .o_age       (w_age_1),
    .o_kill_mask (w_kill_1)
  );

  btag_age_cmp u_age_2 (
    .i_head      (r_head),
    .i_busy      (r_busy),
    .i_tag       (w_res_2.tag),
    .o_age       (w_age_2),
    .o_kill_mask (w_kill_2)
  );

  // The older mispredict wins; the younger one is inside its kill mask.
  assign w_mp_any  = w_mp_1 || w_mp_2;
  assign w_pick_2  = w_mp_2 && (!w_mp_1 || (w_age_2 > w_age_1));
  assign w_mp_tag  = w_pick_2 ? w_res_2.tag : w_res_1.tag;
  assign w_mp_kill = w_pick_2 ? w_kill_2 : w_kill_1;

  always_comb begin
    w_alloc_mask = '0;
    w_clr_mask   = '0;
    if (w_commit) begin
      w_alloc_mask = btag_onehot(r_head);
      if (w_need == 2'd2) w_alloc_mask = w_alloc_mask | btag_onehot(w_head_p1);
    end
    if (w_hit_1 && !w_res_1.mispred) w_clr_mask = w_clr_mask | btag_onehot(w_res_1.tag);
    if (w_hit_2 && !w_res_2.mispred) w_clr_mask = w_clr_mask | btag_onehot(w_res_2.tag);

    w_busy_nxt = (r_busy & ~w_clr_mask) | w_alloc_mask;
    w_head_nxt = w_commit ? (r_head + btag_t'(w_need)) : r_head;
    if (w_mp_any) begin
      w_busy_nxt = r_busy & ~w_clr_mask & ~w_mp_kill & ~btag_onehot(w_mp_tag);
      w_head_nxt = w_mp_tag + btag_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= '0;
      r_head      <= '0;
      r_flush     <= 1'b0;
      r_flush_tag <= '0;
      r_kill      <= '0;
    end else if (flush_all_i) begin
      r_busy  <= '0;
      r_head  <= '0;
      r_flush <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_head  <= w_head_nxt;
      r_flush <= w_mp_any;
      if (w_mp_any) begin
        r_flush_tag <= w_mp_tag;
        r_kill      <= w_mp_kill;
      end
    end
  end

  assign flush_o     = r_flush;
  assign flush_tag_o = r_flush_tag;
  assign kill_mask_o = r_kill;
  assign busy_mask_o = r_busy;

`ifdef BTAG_PERF_CNT_EN
  logic [CNT_BITS-1:0] r_alloc_cnt;
  logic [CNT_BITS-1:0] r_resolve_cnt;
  logic [CNT_BITS-1:0] r_mispred_cnt;
  logic [CNT_BITS-1:0] r_stall_cnt;

  function automatic logic [CNT_BITS-1:0] sat_add(logic [CNT_BITS-1:0] a, logic [1:0] b);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + {{(CNT_BITS-1){1'b0}}, b};
    return s[CNT_BITS] ? '1 : s[CNT_BITS-1:0];
  endfunction

  // Counters survive flush_all_i; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alloc_cnt   <= '0;
      r_resolve_cnt <= '0;
      r_mispred_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (!flush_all_i) begin
        if (w_commit && !w_mp_any) r_alloc_cnt <= sat_add(r_alloc_cnt, w_need);
        r_resolve_cnt <= sat_add(r_resolve_cnt, {1'b0, w_hit_1} + {1'b0, w_hit_2});
        if (w_mp_any) r_mispred_cnt <= sat_add(r_mispred_cnt, 2'd1);
      end
      if (alloc_stall_o && (w_need != 2'd0)) r_stall_cnt <= sat_add(r_stall_cnt, 2'd1);
    end
  end

  assign perf_cnt_o = {r_stall_cnt, r_mispred_cnt, r_resolve_cnt, r_alloc_cnt};
`endif

endmodule
